csa_stream_accum: RTL

Streaming multi-operand accumulator built on a carry-save core. Accepts a packet of WIDTH-bit unsigned operands over a valid/ready interface and keeps the running total in redundant sum/carry form, so each beat costs one full-adder delay. On the packet's last beat it resolves the redundant pair with a chunked multi-cycle carry-propagate adder and presents the result with overflow status. It is the parametrised, sequential successor to the team's fixed 3-operand 4-bit carry-save adder.

---
 rtl/csa_stream_accum.sv | 131 +++++++++++++
 1 files changed

// File: rtl/csa_stream_accum.sv
// Streaming carry-save accumulator: redundant S/C running total, chunked multi-cycle final add.
// Optional build macro CSA_SAT_EN clamps out_sum to all ones on overflow.
module csa_stream_accum #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CHUNK = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int N     = ACC_W / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUTPUT} state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   s_q, c_q, res_q, out_sum_q;
  logic               carry_q, ovf_q, out_ovf_q, in_ready_q, out_valid_q;
  logic [CNT_W-1:0]   cnt_q, out_cnt_q;
  logic [IDX_W-1:0]   idx_q;

  logic               accept;
  logic [ACC_W-1:0]   x_ext, maj, s_acc_d, c_acc_d, res_d, sum_d;
  logic [CHUNK:0]     chunk_sum;
  logic [CNT_W-1:0]   cnt_inc_d;
  logic               ovf_d, last_chunk;

  always_comb begin
    accept     = in_valid && in_ready_q;
    x_ext      = ACC_W'(in_data);
    maj        = (s_q & c_q) | (s_q & x_ext) | (c_q & x_ext);
    s_acc_d    = s_q ^ c_q ^ x_ext;
    c_acc_d    = maj << 1;
    cnt_inc_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    // S and C are shifted down each resolve cycle, so the active chunk is always the low one.
    chunk_sum  = {1'b0, s_q[CHUNK-1:0]} + {1'b0, c_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    res_d      = (res_q >> CHUNK) | (ACC_W'(chunk_sum[CHUNK-1:0]) << (ACC_W - CHUNK));
    ovf_d      = ovf_q | chunk_sum[CHUNK];
    last_chunk = (idx_q == IDX_W'(N - 1));
`ifdef CSA_SAT_EN
    sum_d      = ovf_d ? {ACC_W{1'b1}} : res_d;
`else
    sum_d      = res_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            if (state_q == IDLE) begin
              s_q   <= x_ext;
              c_q   <= '0;
              ovf_q <= 1'b0;
              cnt_q <= CNT_W'(1);
            end else begin
              s_q   <= s_acc_d;
              c_q   <= c_acc_d;
              ovf_q <= ovf_q | maj[ACC_W-1];
              cnt_q <= cnt_inc_d;
            end
            carry_q <= 1'b0;
            idx_q   <= '0;
            if (in_last) begin
              state_q    <= RESOLVE;
              in_ready_q <= 1'b0;
            end else begin
              state_q    <= ACCUM;
            end
          end
        end
        RESOLVE: begin
          s_q     <= s_q >> CHUNK;
          c_q     <= c_q >> CHUNK;
          carry_q <= chunk_sum[CHUNK];
          res_q   <= res_d;
          idx_q   <= idx_q + 1'b1;
          if (last_chunk) begin
            ovf_q       <= ovf_d;
            out_sum_q   <= sum_d;
            out_ovf_q   <= ovf_d;
            out_cnt_q   <= cnt_q;
            out_valid_q <= 1'b1;
            state_q     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_cnt   = out_cnt_q;

endmodule
